rng_seq_ctrl: RTL
=================

Name: rng_seq_ctrl

Overview:
Round sequencer for the memory-pattern game. Each round it draws one value from the 8-bit LFSR random number generator by pulsing its enable, and appends the value's 2 LSBs to a pattern buffer. It then plays the whole pattern on four one-hot lamps and checks the player's button presses against it. It sits between the rng block, the debounced button front-end and the LED/score display logic.

Parameters:
MAX_LEN, 16, pattern buffer depth and winning level (power of two, 2..64)
ON_CYC, 25000000, clock cycles each pattern lamp is lit
OFF_CYC, 12500000, dark clock cycles between lamps
TIMEOUT_CYC, 250000000, player inactivity limit (used only with TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a new game
rng_in  in  8  current rng output
btn_valid  in  1  one-cycle pulse; player pressed btn
btn  in  2  button index 0..3
rng_en  out  1  one-cycle advance request to rng
led  out  4  one-hot lamp during playback, else 0
busy  out  1  high in GEN/SHOW states
await_in  out  1  high in INPUT state
pass  out  1  one-cycle pulse on round success
fail  out  1  level, high in FAIL until next start
win  out  1  level, high in WIN until next start
level  out  clog2(MAX_LEN)+1  current round length, 1..MAX_LEN

Behaviour:
- Reset (async, rst=1): state=IDLE, level=0, index=0, timer=0, all outputs 0. Buffer contents are don't-care.
- IDLE: start -> level=1, GEN_REQ.
- GEN_REQ: rng_en=1 for exactly one cycle -> GEN_CAP.
- GEN_CAP: buf[level-1] <= rng_in[1:0]. The rng updates on the edge that ended GEN_REQ, so the captured value is the new one. index=0 -> SHOW_ON.
- SHOW_ON: led = 1<<buf[index] for ON_CYC cycles -> SHOW_OFF.
- SHOW_OFF: led=0 for OFF_CYC cycles. If index==level-1 -> INPUT with index=0; else index+1 -> SHOW_ON.
- INPUT: await_in=1. On btn_valid, compare btn to buf[index].
  - Mismatch -> FAIL.
  - Match and index<level-1 -> index+1.
  - Match and index==level-1 -> PASS.
- PASS: pass=1 for one cycle. If level==MAX_LEN -> WIN; else level+1 -> GEN_REQ.
- FAIL / WIN: hold; start -> level=1, GEN_REQ (restart).
- Timers count from 0 to N-1 and clear on every state entry, so ON_CYC=4 gives exactly 4 lit cycles.
- btn_valid outside INPUT is ignored. start outside IDLE/FAIL/WIN is ignored.
- start and btn_valid in the same cycle: the state rule applies (in INPUT only btn is seen).
- level never exceeds MAX_LEN. index never exceeds level-1.
- rst mid-round aborts immediately to IDLE. No partial pass/fail pulse is emitted.
- Only GEN_REQ drives rng_en; the rng is never advanced in any other state.

Optional Feature:
TIMEOUT_EN
- Defined: INPUT runs an inactivity timer, reloaded on state entry and on every accepted press. Reaching TIMEOUT_CYC-1 with no press -> FAIL.
- Undefined: no timer logic; INPUT waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Shared package: state encoding constants (IDLE, GEN_REQ, GEN_CAP, SHOW_ON, SHOW_OFF, INPUT, PASS, FAIL, WIN), the lamp-index width (2), and default ON/OFF/TIMEOUT cycle counts.
- One natural sub-module, seq_buf: MAX_LEN x 2-bit register file with synchronous write and combinational read by index. Contents are not reset.

Test Plan:
Test parameters: ON_CYC=4, OFF_CYC=2, MAX_LEN=4, TIMEOUT_CYC=20. Bench stubs rng_in.
- Basic round: rng_in=0x02, start -> rng_en high exactly 1 cycle; led=4'b0100 for 4 cycles, 0 for 2; await_in=1; btn=2 -> pass pulse, level=2, rng_en pulses again.
- Fail: after round 1 with value 2, btn=1 -> fail=1, await_in=0; led stays 0; next start -> level=1.
- Win: rng_in=0x03,0x00,0x01,0x02 over 4 rounds, correct presses each round -> win=1 after 4th pass, level=4; further btn_valid has no effect.
- Ignore/overlap: btn_valid pulses during SHOW_ON and a start during INPUT -> no state change, pattern playback timing unchanged.
- Reset mid-playback: rst asserted during 2nd lamp of level 3 -> led, rng_en, pass, fail, win all 0 and level=0 in the same cycle; start then replays from level 1.
- TIMEOUT_EN defined: no press for 20 cycles in INPUT -> fail=1. With a press at cycle 19 -> timer reloads, no fail. Undefined: 100 idle cycles -> still INPUT.

Source files
------------

// File: rtl/rng_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_seq_ctrl_pkg
// Brief    : Shared state encoding, lamp-index width and default timings
//            for the memory-pattern round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rng_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GEN_REQ  = 4'd1,
        ST_GEN_CAP  = 4'd2,
        ST_SHOW_ON  = 4'd3,
        ST_SHOW_OFF = 4'd4,
        ST_INPUT    = 4'd5,
        ST_PASS     = 4'd6,
        ST_FAIL     = 4'd7,
        ST_WIN      = 4'd8
    } state_t;

    localparam int c_lamp_w          = 2;
    localparam int c_tmr_w           = 32;
    localparam int c_on_cyc_def      = 25000000;
    localparam int c_off_cyc_def     = 12500000;
    localparam int c_timeout_cyc_def = 250000000;

endpackage
`default_nettype wire

// File: rtl/rng_seq_ctrl_seq_buf.sv
`default_nettype none
// ============================================================================
// Module   : rng_seq_ctrl_seq_buf
// Brief    : Pattern buffer, DEPTH x DW register file, synchronous write and
//            combinational read. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module rng_seq_ctrl_seq_buf
    import rng_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = c_lamp_w
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/rng_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rng_seq_ctrl
// Brief    : Round sequencer: draws from the rng, plays the pattern on four
//            lamps and checks the player's presses.
// Config   : define TIMEOUT_EN to fail the round after TIMEOUT_CYC idle cycles
// Revision : 1.0 - initial release
// ============================================================================
module rng_seq_ctrl
    import rng_seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int ON_CYC      = c_on_cyc_def,
    parameter int OFF_CYC     = c_off_cyc_def,
    parameter int TIMEOUT_CYC = c_timeout_cyc_def
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               rng_in,
    input  logic                     btn_valid,
    input  logic [1:0]               btn,
    output logic                     rng_en,
    output logic [3:0]               led,
    output logic                     busy,
    output logic                     await_in,
    output logic                     pass,
    output logic                     fail,
    output logic                     win,
    output logic [$clog2(MAX_LEN):0] level
);

    localparam int c_iw = $clog2(MAX_LEN);
    localparam int c_lw = c_iw + 1;

    state_t              r_state;
    state_t              w_next;
    logic [c_tmr_w-1:0]  r_timer;
    logic [c_lw-1:0]     r_level;
    logic [c_iw-1:0]     r_index;
    logic [c_lw-1:0]     w_lvl_m1;
    logic [c_lamp_w-1:0] w_rd_data;
    logic                w_last;
    logic                w_match;
    logic                w_at_max;
    logic                w_on_done;
    logic                w_off_done;
    logic                w_to_done;
    logic                w_tmr_clr;
    logic                w_unused;

    assign w_lvl_m1   = r_level - c_lw'(1);
    assign w_last     = (r_index == w_lvl_m1[c_iw-1:0]);
    assign w_match    = (btn == w_rd_data);
    assign w_at_max   = (r_level == c_lw'(MAX_LEN));
    assign w_on_done  = (r_timer == c_tmr_w'(ON_CYC - 1));
    assign w_off_done = (r_timer == c_tmr_w'(OFF_CYC - 1));

`ifdef TIMEOUT_EN
    assign w_to_done = (r_timer == c_tmr_w'(TIMEOUT_CYC - 1));
    assign w_unused  = ^{1'b0, rng_in[7:2]};
`else
    assign w_to_done = 1'b0;
    assign w_unused  = ^{1'b0, rng_in[7:2], c_tmr_w'(TIMEOUT_CYC)};
`endif

    // An accepted press restarts the timer even though the state is unchanged.
    assign w_tmr_clr = (w_next != r_state) || ((r_state == ST_INPUT) && btn_valid);

    rng_seq_ctrl_seq_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_iw),
        .DW    (c_lamp_w)
    ) u_seq_buf (
        .clk   (clk),
        .we    (r_state == ST_GEN_CAP),
        .waddr (w_lvl_m1[c_iw-1:0]),
        .wdata (rng_in[c_lamp_w-1:0]),
        .raddr (r_index),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_level <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_tmr_clr ? '0 : r_timer + c_tmr_w'(1);
            case (r_state)
                ST_IDLE, ST_FAIL, ST_WIN: begin
                    if (start) begin
                        r_level <= c_lw'(1);
                        r_index <= '0;
                    end
                end
                ST_GEN_CAP: r_index <= '0;
                ST_SHOW_OFF: begin
                    if (w_off_done) begin
                        r_index <= w_last ? '0 : r_index + c_iw'(1);
                    end
                end
                ST_INPUT: begin
                    if (btn_valid && w_match && !w_last) begin
                        r_index <= r_index + c_iw'(1);
                    end
                end
                ST_PASS: begin
                    if (!w_at_max) begin
                        r_level <= r_level + c_lw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_FAIL, ST_WIN: if (start) w_next = ST_GEN_REQ;
            ST_GEN_REQ:  w_next = ST_GEN_CAP;
            ST_GEN_CAP:  w_next = ST_SHOW_ON;
            ST_SHOW_ON:  if (w_on_done) w_next = ST_SHOW_OFF;
            ST_SHOW_OFF: if (w_off_done) w_next = w_last ? ST_INPUT : ST_SHOW_ON;
            ST_INPUT: begin
                if (btn_valid) begin
                    if (!w_match) begin
                        w_next = ST_FAIL;
                    end else if (w_last) begin
                        w_next = ST_PASS;
                    end
                end else if (w_to_done) begin
                    w_next = ST_FAIL;
                end
            end
            ST_PASS:     w_next = w_at_max ? ST_WIN : ST_GEN_REQ;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Outputs decode the state register so an async reset clears them at once.
    assign rng_en   = (r_state == ST_GEN_REQ);
    assign led      = (r_state == ST_SHOW_ON) ? (4'b0001 << w_rd_data) : 4'b0000;
    assign busy     = (r_state == ST_GEN_REQ) || (r_state == ST_GEN_CAP) ||
                      (r_state == ST_SHOW_ON) || (r_state == ST_SHOW_OFF);
    assign await_in = (r_state == ST_INPUT);
    assign pass     = (r_state == ST_PASS);
    assign fail     = (r_state == ST_FAIL);
    assign win      = (r_state == ST_WIN);
    assign level    = r_level;

endmodule
`default_nettype wire
